// File: rtl/imem_loader.sv
// Streams bytes into instruction memory at consecutive addresses, then zero-pads a partial last word.
// Latency: each accepted byte is written one cycle after its handshake edge; PAD writes follow back-to-back.
// Backpressure: byte_ready is high only in LOAD; busy holds the pipeline until done or error.
module imem_loader #(
  parameter int          ADDR_W   = 9,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            ptr        <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= byte_data;
            if (ptr[1:0] == 2'd3)
              word_count <= word_count + 1'b1;
            // Pointer saturates at the top so it only returns to 0 via start.
            if (ptr != PTR_MAX)
              ptr <= ptr + 1'b1;
            if (byte_last) begin
              byte_ready <= 1'b0;
              if (ptr[1:0] == 2'd3) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                state <= S_PAD;
              end
            end else if (ptr == PTR_MAX) begin
              byte_ready <= 1'b0;
              error      <= 1'b1;
              busy       <= 1'b0;
              state      <= S_ERR;
            end
          end
        end
        S_PAD: begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= PAD_BYTE;
          if (ptr != PTR_MAX)
            ptr <= ptr + 1'b1;
          if (ptr[1:0] == 2'd3) begin
            word_count <= word_count + 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write stream captured by a monitor, compared to hand-computed values.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_last = 1'b0;
  logic       byte_ready, mem_we, busy, done, error;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] word_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         wq_addr[$];
  logic [7:0] wq_data[$];
  int         wq_cyc[$];

  imem_loader #(.ADDR_W(9), .PAD_BYTE(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc = 1'b0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (byte_ready) acc = 1'b1;
    end
    if (acc) begin
      @(posedge clk); #1;
    end
    check("accept", 32'(acc), 32'd1);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  logic [7:0] t1_bytes [8];
  int bad;

  initial begin
    t1_bytes = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state
    #2 reset = 1'b0;
    #2;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we",    32'(mem_we),     32'd0);
    check("rst_addr",  32'(mem_addr),   32'd0);
    check("rst_wdata", 32'(mem_wdata),  32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_error", 32'(error),      32'd0);
    check("rst_wc",    32'(word_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Eight-byte program, word aligned
    clear_q();
    do_start();
    check("t1_ready", 32'(byte_ready), 32'd1);
    check("t1_busy",  32'(busy),       32'd1);
    for (int i = 0; i < 8; i++) send_byte(t1_bytes[i], i == 7);
    wait_idle();
    check("t1_done", 32'(done),       32'd1);
    check("t1_busy_end", 32'(busy),   32'd0);
    check("t1_wc",   32'(word_count), 32'd2);
    check("t1_nwr",  32'(wq_addr.size()), 32'd8);
    if (wq_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t1_addr", 32'(wq_addr[i]), 32'(i));
        check("t1_data", 32'(wq_data[i]), 32'(t1_bytes[i]));
      end
      check("t1_b2b", 32'(wq_cyc[7] - wq_cyc[0]), 32'd7);
    end

    // Five bytes followed by three pad writes
    clear_q();
    do_start();
    for (int i = 0; i < 5; i++) send_byte(8'hAA + 8'(i), i == 4);
    wait_idle();
    check("t2_done", 32'(done),       32'd1);
    check("t2_wc",   32'(word_count), 32'd2);
    check("t2_nwr",  32'(wq_addr.size()), 32'd8);
    if (wq_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_addr", 32'(wq_addr[i]), 32'(i));
        check("t2_data", 32'(wq_data[i]), (i < 5) ? 32'(8'hAA + i) : 32'd0);
      end
      check("t2_pad_gapless", 32'(wq_cyc[7] - wq_cyc[4]), 32'd3);
    end

    // Full memory with last on byte 512
    clear_q();
    do_start();
    for (int i = 0; i < 512; i++) send_byte(8'(i), i == 511);
    wait_idle();
    check("t3_done",  32'(done),       32'd1);
    check("t3_error", 32'(error),      32'd0);
    check("t3_wc",    32'(word_count), 32'd128);
    check("t3_nwr",   32'(wq_addr.size()), 32'd512);
    if (wq_addr.size() == 512) begin
      bad = 0;
      for (int i = 0; i < 512; i++)
        if (wq_addr[i] != i || wq_data[i] != 8'(i)) bad++;
      check("t3_seq", 32'(bad), 32'd0);
      check("t3_last_addr", 32'(wq_addr[511]), 32'd511);
    end

    // Full memory without last: overflow
    clear_q();
    do_start();
    for (int i = 0; i < 512; i++) send_byte(8'(i ^ 8'h5A), 1'b0);
    wait_idle();
    check("t3b_error", 32'(error),      32'd1);
    check("t3b_done",  32'(done),       32'd0);
    check("t3b_ready", 32'(byte_ready), 32'd0);
    check("t3b_wc",    32'(word_count), 32'd128);
    check("t3b_nwr",   32'(wq_addr.size()), 32'd512);
    if (wq_addr.size() == 512) begin
      check("t3b_last_addr", 32'(wq_addr[511]), 32'd511);
      check("t3b_last_data", 32'(wq_data[511]), 32'(8'hFF ^ 8'h5A));
    end
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (10) @(negedge clk);
    check("t3b_513th_nwr", 32'(wq_addr.size()), 32'd512);
    check("t3b_513th_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    @(posedge clk); #1;

    // Gapped valid
    clear_q();
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10 + 8'(i), i == 3);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
    check("t4_done", 32'(done),       32'd1);
    check("t4_wc",   32'(word_count), 32'd1);
    check("t4_nwr",  32'(wq_addr.size()), 32'd4);
    if (wq_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t4_addr", 32'(wq_addr[i]), 32'(i));
        check("t4_data", 32'(wq_data[i]), 32'(8'h10 + i));
      end
      for (int i = 1; i < 4; i++)
        check("t4_spacing", 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd2);
    end

    // start mid-load is ignored
    clear_q();
    do_start();
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    do_start();
    send_byte(8'hC3, 1'b1);
    wait_idle();
    check("t5_done", 32'(done),       32'd1);
    check("t5_wc",   32'(word_count), 32'd1);
    check("t5_nwr",  32'(wq_addr.size()), 32'd4);
    if (wq_addr.size() == 4) begin
      check("t5_addr3", 32'(wq_addr[3]), 32'd3);
      check("t5_data3", 32'(wq_data[3]), 32'hC3);
    end

    // Asynchronous reset mid-load
    do_start();
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b0);
    #2;
    check("t6_pre_we", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_busy",  32'(busy),       32'd0);
    check("t6_we",    32'(mem_we),     32'd0);
    check("t6_wc",    32'(word_count), 32'd0);
    check("t6_ready", 32'(byte_ready), 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    clear_q();
    do_start();
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), i == 3);
    wait_idle();
    check("t6_done", 32'(done),       32'd1);
    check("t6_wc2",  32'(word_count), 32'd1);
    check("t6_nwr",  32'(wq_addr.size()), 32'd4);
    if (wq_addr.size() == 4)
      for (int i = 0; i < 4; i++)
        check("t6_addr", 32'(wq_addr[i]), 32'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
